// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it feeds.
// The optional checksum feature is selected by IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_WIDTH  = 32;
    localparam int BYTES_PER_WORD = DEFAULT_WIDTH / 8;
    localparam int LEN_BYTES      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } loader_state_t;

    // States during which the core must be held and the byte stream is open.
    function automatic logic in_session(loader_state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: the first byte of a word lands in bits [7:0].
// word/word_valid are combinational so the word is usable on the edge of its last byte.
module byte_word_packer
    import imem_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);

    localparam int BPW   = WIDTH / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last       = (cnt == CNT_W'(BPW - 1));
    assign word_valid = byte_valid && last;

    generate
        if (WIDTH > 8) begin : g_shift
            // Only the upper WIDTH-8 bits need storage; the newest byte enters at the top.
            logic [WIDTH-9:0] shreg;

            assign word = {byte_data, shreg};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shreg <= '0;
                end else if (byte_valid && !clear) begin
                    shreg <= word[WIDTH-1:8];
                end
            end
        end else begin : g_byte
            assign word = byte_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_valid) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> sequential instruction-memory writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = ST_CSUM;
`else
    localparam loader_state_t AFTER_DATA = ST_DONE;
`endif

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    loader_state_t    state;
    logic             len_cnt;
    logic [7:0]       len_lo;
    logic [15:0]      len_n;
    logic [ADDR_W:0]  n_words;
    logic [ADDR_W:0]  word_cnt;
    logic             xfer;
    logic             start_ok;
    logic             pack_valid;
    logic [WIDTH-1:0] pack_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign xfer     = s_valid && s_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign len_n    = {s_data, len_lo};

    byte_word_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (xfer && (state == ST_DATA)),
        .byte_data  (s_data),
        .word_valid (pack_valid),
        .word       (pack_word)
    );

    always_ff @(posedge clk or posedge rst) begin : fsm
        loader_state_t nxt;
        if (rst) begin
            state     <= ST_IDLE;
            len_cnt   <= 1'b0;
            len_lo    <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            // NOTE: nxt is a blocking scratch variable local to this block; every
            // register below is still updated with <= so the FSM stays edge-accurate.
            nxt    = state;
            mem_we <= 1'b0;

            // The word is registered here and written one cycle after its last byte.
            if (pack_valid) begin
                mem_we    <= 1'b1;
                mem_wdata <= pack_word;
                mem_addr  <= word_cnt[ADDR_W-1:0];
                word_cnt  <= word_cnt + 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        nxt      = ST_LEN;
                        err      <= 1'b0;
                        len_cnt  <= 1'b0;
                        word_cnt <= '0;
                        mem_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        if (len_cnt != 1'(LEN_BYTES - 1)) begin
                            len_lo  <= s_data;
                            len_cnt <= 1'b1;
                        end else if ({1'b0, len_n} > DEPTH_L) begin
                            err <= 1'b1;
                            nxt = ST_DONE;
                        end else if (len_n == '0) begin
                            nxt = AFTER_DATA;
                        end else begin
                            n_words <= len_n[ADDR_W:0];
                            nxt = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ s_data;
`endif
                        if (pack_valid && ((word_cnt + 1'b1) == n_words)) begin
                            nxt = AFTER_DATA;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        if (s_data != csum) begin
                            err <= 1'b1;
                        end
                        nxt = ST_DONE;
                    end
                end
`endif
                default: nxt = ST_IDLE;
            endcase

            state    <= nxt;
            s_ready  <= in_session(nxt);
            busy     <= in_session(nxt);
            cpu_hold <= in_session(nxt);
            done     <= (nxt == ST_DONE);
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake and assembles little-endian instruction words.
- Writes each word to sequential instruction-memory addresses through a synchronous write port.
- Holds the core in reset while loading, so programs no longer have to be baked into initial blocks.
- Sits between a host byte source (UART RX / testbench) and the instruction memory's write port.

Parameters:
- DEPTH, 256, number of instruction words in memory; maximum program length.
- WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_W, $clog2(DEPTH), word-address width of the memory port.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session; ignored unless in IDLE or DONE.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  WIDTH  assembled instruction word.
- busy  output  1  session in progress (LEN, DATA, CSUM).
- done  output  1  session finished; sticky until next start.
- err  output  1  session failed; sticky until next start.
- cpu_hold  output  1  core reset request; equals busy.

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=0. FSM goes to IDLE, and all counters are cleared. Reset mid-session aborts the session; no further writes occur.
- Byte transfer occurs when s_valid && s_ready. s_ready is 1 exactly in LEN, DATA and CSUM.
- FSM states: IDLE, LEN, DATA, CSUM, DONE.
- IDLE/DONE + start -> LEN. On entry, clear done, err, byte counter, word counter and mem_addr.
- LEN:
  - Accept 2 bytes: word count N, little-endian (first byte = N[7:0]).
  - After the 2nd byte, if N > DEPTH: set err, go to DONE, perform no writes.
  - If N == 0: go to CSUM when enabled, else DONE.
  - Otherwise go to DATA.
- DATA:
  - Shift bytes in little-endian order (first byte = bits [7:0]).
  - On the WIDTH/8-th byte of a word, the next cycle drives mem_we=1 with mem_wdata = the assembled word and mem_addr = word index.
  - mem_addr increments after each write.
  - Transfers are back-to-back capable: a byte may be accepted on the same cycle mem_we is high.
  - After word N-1 is written, go to CSUM when enabled, else DONE.
- Word counter is ADDR_W+1 bits wide so that N == DEPTH is representable. mem_addr never wraps within a session.
- Stalls: s_valid low holds all state. There is no timeout.
- start while busy is ignored.
- DONE: done=1, busy=0. Memory contents remain valid.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers every data byte (length bytes excluded).
  - The CSUM state accepts one byte. If it differs from the running XOR: err=1. Either way, go to DONE.
  - Written words are not rolled back on error.
- Undefined: the CSUM state and the XOR register do not exist. DATA and zero-length go directly to DONE.

Decomposition:
- Shared package imem_pkg:
  - FSM state enum loader_state_t.
  - Constants BYTES_PER_WORD = WIDTH/8 and LEN_BYTES = 2.
  - Default DEPTH/WIDTH shared with the instruction memory.
- Sub-module: byte_word_packer, a shift register plus byte counter that emits word_valid on the last byte. It is instantiated once.

Test Plan:
- Reset then start; stream 02 00, 13 01 50 00, 93 01 C0 00 -> mem_we pulses twice: addr 0 data 0x00500113, addr 1 data 0x00C00193; done=1, err=0; cpu_hold high only during the session.
- Length 0x0101 (257 > DEPTH) -> err=1, done=1, zero mem_we pulses.
- Same 2-word load with s_valid toggled randomly 50% -> identical writes; no byte lost or duplicated.
- Assert rst after the 5th data byte -> all outputs return to reset values immediately. A fresh start + 1-word load writes addr 0 correctly.
- start pulsed mid-DATA -> ignored; addresses continue in sequence.
- With IMEM_LOADER_CHECKSUM_EN: 1 word 13 01 50 00, checksum 0x42 -> err=0. Same stream with checksum 0x43 -> err=1, word still written at addr 0.
